// File: rtl/ram_pkg.sv
// Shared encodings for the byte-masked true-dual-port RAM family.
// The read-during-write mode is selected per instance through RDW_MODE.
package ram_pkg;

   typedef enum logic [1:0] {
      RDW_READ_FIRST  = 2'd0,
      RDW_WRITE_FIRST = 2'd1,
      RDW_NO_CHANGE   = 2'd2
   } rdw_mode_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result pipeline for one RAM port: RD_LATENCY stages of data + valid.
// The last stage only loads when a result arrives, so dout holds between reads.
module ram_rd_pipe
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [DATA_WIDTH-1:0] r_data [RD_LATENCY];
   logic [RD_LATENCY-1:0] r_valid;

   // Advance results one stage per cycle; data registers load only behind a valid
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         if (i_valid) begin
            r_data[0] <= i_data;
         end
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) begin
               r_data[i] <= r_data[i-1];
            end
         end
      end
   end

   assign o_valid = r_valid[RD_LATENCY-1];
   assign o_data  = r_data[RD_LATENCY-1];

endmodule

// File: rtl/ram_tdp_bytemask_pipe.sv
// True-dual-port RAM with byte-lane write masks, lane-level collision priority,
// selectable read-during-write mode and a 1- or 2-cycle registered read path.
module ram_tdp_bytemask_pipe
   import ram_pkg::*;
#(
   parameter int        DATA_WIDTH = 32,
   parameter int        DEPTH      = 16,
   parameter int        BYTE_WIDTH = 8,
   parameter int        RD_LATENCY = 1,
   parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST,
   parameter bit        PRIO_B     = 1'b0,
   localparam int       ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int       BWEN_WIDTH = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cen_a,
   input  logic                  wen_a,
   input  logic [BWEN_WIDTH-1:0] bwen_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   output logic                  rvalid_a,
   input  logic                  cen_b,
   input  logic                  wen_b,
   input  logic [BWEN_WIDTH-1:0] bwen_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b,
   output logic                  rvalid_b,
   output logic                  collision
);

   generate
      if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
         $error("ram_tdp_bytemask_pipe: RD_LATENCY must be 1 or 2");
      end
      if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
         $error("ram_tdp_bytemask_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
   endgenerate

   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  r_collision;

   logic                  w_ok_a, w_ok_b, w_wr_a, w_wr_b, w_same, w_coll;
   logic [BWEN_WIDTH-1:0] w_lane_a, w_lane_b, w_keep_a, w_keep_b;
   logic [DATA_WIDTH-1:0] w_old_a, w_old_b, w_rd_data_a, w_rd_data_b;
   logic                  w_rd_req_a, w_rd_req_b;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [BWEN_WIDTH-1:0] mask
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < BWEN_WIDTH; i++) begin
         if (mask[i]) begin
            res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      return res;
   endfunction

   assign w_ok_a   = ({1'b0, addr_a} < DEPTH_L);
   assign w_ok_b   = ({1'b0, addr_b} < DEPTH_L);
   assign w_wr_a   = cen_a & wen_a & w_ok_a;
   assign w_wr_b   = cen_b & wen_b & w_ok_b;
   assign w_same   = (addr_a == addr_b);
   assign w_lane_a = bwen_a & {BWEN_WIDTH{w_wr_a}};
   assign w_lane_b = bwen_b & {BWEN_WIDTH{w_wr_b}};
   assign w_coll   = w_same & (|(w_lane_a & w_lane_b));

   // On a shared lane of the same word only the priority port keeps its enable
   assign w_keep_a = w_lane_a & ~({BWEN_WIDTH{w_same &  PRIO_B}} & w_lane_b);
   assign w_keep_b = w_lane_b & ~({BWEN_WIDTH{w_same & ~PRIO_B}} & w_lane_a);

   // Storage stays outside the reset domain; writes are suppressed while reset is held
   always_ff @(posedge clock) begin
      if (reset_n) begin
         for (int i = 0; i < BWEN_WIDTH; i++) begin
            if (w_keep_a[i]) begin
               r_mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (w_keep_b[i]) begin
               r_mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   assign w_old_a = r_mem[addr_a];
   assign w_old_b = r_mem[addr_b];

   assign w_rd_data_a = ((RDW_MODE == RDW_WRITE_FIRST) && wen_a) ?
                        merge_lanes(w_old_a, din_a, bwen_a) : w_old_a;
   assign w_rd_data_b = ((RDW_MODE == RDW_WRITE_FIRST) && wen_b) ?
                        merge_lanes(w_old_b, din_b, bwen_b) : w_old_b;

   assign w_rd_req_a = cen_a & (~wen_a | (RDW_MODE != RDW_NO_CHANGE));
   assign w_rd_req_b = cen_b & (~wen_b | (RDW_MODE != RDW_NO_CHANGE));

   // Collision flag is a one-cycle registered pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_collision <= 1'b0;
      end else begin
         r_collision <= w_coll;
      end
   end

   assign collision = r_collision;

   ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe_a (
      .clock   (clock),
      .reset_n (reset_n),
      .i_valid (w_rd_req_a),
      .i_data  (w_rd_data_a),
      .o_valid (rvalid_a),
      .o_data  (dout_a)
   );

   ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe_b (
      .clock   (clock),
      .reset_n (reset_n),
      .i_valid (w_rd_req_b),
      .i_data  (w_rd_data_b),
      .o_valid (rvalid_b),
      .o_data  (dout_b)
   );

endmodule
